// File: rtl/bch_deser_pkg.sv
// Shared constants and helpers for the BCH data deserializer.
// Build option: BCH_DESER_DROP_COUNT_EN enables the drop counter.
package bch_deser_pkg;

   localparam int DROP_CNT_W = 16;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/bch_word_fifo.sv
// Word FIFO with wrap-bit pointers, level and full/empty flags.
// Head word is driven straight from memory (no output register).
module bch_word_fifo
   import bch_deser_pkg::*;
#(
   parameter int W     = 5,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [clog2(DEPTH):0]  level
);

   localparam int AW = clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q[AW-1:0]];
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
   assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/bch_data_deserializer.sv
// Packs the decoder's serial data bits into K-bit words behind a FIFO.
// Define BCH_DESER_DROP_COUNT_EN to build the saturating drop counter.
module bch_data_deserializer
   import bch_deser_pkg::*;
#(
   parameter int K     = 5,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vdin,
   input  logic                  din,
   input  logic                  clear,
   output logic [K-1:0]          data_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [clog2(DEPTH):0] level,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_count
);

   localparam int CW = clog2(K);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [K-2:0]  asm_q, asm_d;
   logic          ovf_q, ovf_d;
   logic [K-1:0]  word;
   logic          last, pop, wr_en, drop;
   logic          full, empty;

   assign word  = {asm_q, din};
   assign last  = vdin && (cnt_q == CW'(K - 1));
   assign pop   = !empty && ready_in;
   // A full FIFO still takes the word if the head leaves this edge.
   assign wr_en = last && (!full || pop);
   assign drop  = last && full && !pop;

   always_comb begin
      asm_d = asm_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (vdin) begin
         asm_d = word[K-2:0];
         cnt_d = last ? '0 : cnt_q + 1'b1;
      end
      if (clear)     ovf_d = 1'b0;
      else if (drop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         asm_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         asm_q <= asm_d;
         ovf_q <= ovf_d;
      end
   end

   assign overflow  = ovf_q;
   assign valid_out = !empty;

`ifdef BCH_DESER_DROP_COUNT_EN
   logic [DROP_CNT_W-1:0] dcnt_q, dcnt_d;

   always_comb begin
      dcnt_d = dcnt_q;
      if (clear)
         dcnt_d = '0;
      else if (drop && dcnt_q != DROP_CNT_MAX)
         dcnt_d = dcnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) dcnt_q <= '0;
      else        dcnt_q <= dcnt_d;
   end

   assign drop_count = dcnt_q;
`else
   assign drop_count = '0;
`endif

   bch_word_fifo #(
      .W     (K),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_en),
      .pop   (pop),
      .wdata (word),
      .rdata (data_out),
      .full  (full),
      .empty (empty),
      .level (level)
   );

endmodule

// File: tb/tb_bch_data_deserializer.sv
// Directed bench for bch_data_deserializer with K=5, DEPTH=4.
// Table vectors for plain words and gaps, hand sequences for FIFO corners.
module tb_bch_data_deserializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        vdin, din, clear, ready_in;
   logic [4:0]  data_out;
   logic        valid_out;
   logic [2:0]  level;
   logic        overflow;
   logic [15:0] drop_count;

   int errors = 0;
   int checks = 0;

`ifdef BCH_DESER_DROP_COUNT_EN
   localparam logic [15:0] DC_ONE = 16'd1;
`else
   localparam logic [15:0] DC_ONE = 16'd0;
`endif

   always #5 clk = ~clk;

   bch_data_deserializer #(.K(5), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .vdin       (vdin),
      .din        (din),
      .clear      (clear),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .ready_in   (ready_in),
      .level      (level),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   typedef struct {
      logic       vdin;
      logic       din;
      logic       rdy;
      logic [4:0] exp_data;
      logic       exp_valid;
      logic [2:0] exp_level;
   } vec_t;

   vec_t tbl[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_word(input logic [4:0] w, input logic last_rdy,
                            input logic last_clr);
      for (int i = 4; i >= 0; i--) begin
         vdin = 1'b1;
         din  = w[i];
         if (i == 0) begin
            ready_in = last_rdy;
            clear    = last_clr;
         end
         tick();
      end
      vdin  = 1'b0;
      din   = 1'b0;
      clear = 1'b0;
   endtask

   task automatic fill4();
      ready_in = 1'b0;
      for (int w = 1; w <= 4; w++) send_word(5'(w), 1'b0, 1'b0);
      check("fill_level", level, 3'd4);
   endtask

   task automatic drain(input int first, input int n, input string tag);
      ready_in = 1'b1;
      for (int i = 0; i < n; i++) begin
         check({tag, "_valid"}, valid_out, 1'b1);
         check({tag, "_data"}, data_out, first + i);
         tick();
      end
      ready_in = 1'b0;
      check({tag, "_empty"}, valid_out, 1'b0);
      check({tag, "_level0"}, level, 3'd0);
   endtask

   initial begin
      reset    = 1'b0;
      vdin     = 1'b0;
      din      = 1'b0;
      clear    = 1'b0;
      ready_in = 1'b1;
      tick();
      check("rst_valid", valid_out, 1'b0);
      check("rst_level", level, 3'd0);
      check("rst_data", data_out, 5'd0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_dc", drop_count, 16'd0);
      reset = 1'b1;
      tick();

      // basic word 10110
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 5'h00, 1'b0, 3'd0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 5'h00, 1'b0, 3'd0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 5'h00, 1'b0, 3'd0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 5'h00, 1'b0, 3'd0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 5'h16, 1'b1, 3'd1});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 5'h00, 1'b0, 3'd0});
      // gapped word 11 ... 001
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 5'h00, 1'b0, 3'd0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 5'h00, 1'b0, 3'd0});
      for (int i = 0; i < 7; i++)
         tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 5'h00, 1'b0, 3'd0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 5'h00, 1'b0, 3'd0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 5'h00, 1'b0, 3'd0});
      tbl.push_back(vec_t'{1'b1, 1'b1, 1'b1, 5'h19, 1'b1, 3'd1});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 5'h00, 1'b0, 3'd0});

      foreach (tbl[i]) begin
         vdin     = tbl[i].vdin;
         din      = tbl[i].din;
         ready_in = tbl[i].rdy;
         tick();
         check($sformatf("vec%0d_valid", i), valid_out, tbl[i].exp_valid);
         check($sformatf("vec%0d_level", i), level, tbl[i].exp_level);
         if (tbl[i].exp_valid)
            check($sformatf("vec%0d_data", i), data_out, tbl[i].exp_data);
      end
      vdin = 1'b0;

      // overflow: fifth word dropped while consumer stalls
      fill4();
      check("ovf_head", data_out, 5'h01);
      check("ovf_pre", overflow, 1'b0);
      send_word(5'h05, 1'b0, 1'b0);
      check("ovf_level", level, 3'd4);
      check("ovf_flag", overflow, 1'b1);
      check("ovf_dc", drop_count, DC_ONE);
      drain(1, 4, "ovf_pop");

      // reset mid-word with one word stored and overflow set
      send_word(5'h0A, 1'b0, 1'b0);
      vdin = 1'b1; din = 1'b1; tick();
      din = 1'b0; tick();
      din = 1'b1; tick();
      vdin = 1'b0;
      check("pre_rst_level", level, 3'd1);
      reset = 1'b0;
      #1;
      check("mid_rst_valid", valid_out, 1'b0);
      check("mid_rst_level", level, 3'd0);
      check("mid_rst_data", data_out, 5'd0);
      check("mid_rst_ovf", overflow, 1'b0);
      check("mid_rst_dc", drop_count, 16'd0);
      tick();
      reset = 1'b1;
      send_word(5'h13, 1'b0, 1'b0);
      check("post_rst_level", level, 3'd1);
      drain(5'h13, 1, "post_rst");

      // full FIFO with pop on the completing edge
      fill4();
      send_word(5'h05, 1'b1, 1'b0);
      ready_in = 1'b0;
      check("fp_level", level, 3'd4);
      check("fp_ovf", overflow, 1'b0);
      check("fp_dc", drop_count, 16'd0);
      drain(2, 4, "fp_pop");

      // clear after a drop, then clear racing a drop
      fill4();
      send_word(5'h06, 1'b0, 1'b0);
      check("clr_pre_ovf", overflow, 1'b1);
      check("clr_pre_dc", drop_count, DC_ONE);
      tick();
      check("clr_sticky", overflow, 1'b1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_ovf", overflow, 1'b0);
      check("clr_dc", drop_count, 16'd0);
      check("clr_level", level, 3'd4);
      send_word(5'h07, 1'b0, 1'b1);
      check("clr_race_ovf", overflow, 1'b0);
      check("clr_race_dc", drop_count, 16'd0);
      check("clr_race_level", level, 3'd4);
      drain(1, 4, "clr_pop");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
